if_prefetch_unit: RTL

//   Parametrised instruction-fetch front end for the 5-stage RISC-V core; replaces the single-register IF stage.

---
 rtl/if_prefetch_unit_pkg.sv | 22 ++
 rtl/if_prefetch_unit_if.sv | 29 ++
 rtl/if_prefetch_unit_sync_fifo.sv | 63 ++++++
 rtl/if_prefetch_unit.sv | 89 ++++++++
 4 files changed

// File: rtl/if_prefetch_unit_pkg.sv
// Shared core constants for the instruction-fetch front end.
//   CORE_XLEN     default address/instruction width (RV32I)
//   DEPTH_DEF     default prefetch queue depth
//   RESET_PC_DEF  default fetch address after reset
//   INST_NOP      canonical RV32I nop (addi x0,x0,0)
//   OP_*          major opcode constants shared with decode
package if_prefetch_unit_pkg;
  localparam int          CORE_XLEN    = 32;
  localparam int          DEPTH_DEF    = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
endpackage

// File: rtl/if_prefetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel plus
// the decode-side valid/ready channel.
//   master : the prefetch unit (drives requests and decode head)
//   slave  : memory + decode environment
interface if_prefetch_unit_if
  import if_prefetch_unit_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_inst;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );
endinterface

// File: rtl/if_prefetch_unit_sync_fifo.sv
// Synchronous FIFO holding {pc,inst} prefetch entries.
//   clk, rst     clock / async active-high reset
//   push, data   write an entry (caller guarantees space via credits)
//   pop          remove head (ignored when empty)
//   flush        drop all entries; wins over push/pop
//   head_data    head entry, zero when empty
//   empty, count occupancy status
module sync_fifo
  import if_prefetch_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        full, do_push, do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_push   = push && !flush;
  assign do_pop    = pop && !empty && !flush;
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Credit accounting upstream must never let a push land on a full queue
  // unless the head leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(do_push && full && !do_pop));
  end
endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: streams sequential word fetches to a
// request/response instruction memory, buffers {pc,inst} pairs and hands
// them to decode; a redirect from MEM flushes and restarts the stream.
//   clk, rst        clock / async active-high reset
//   bus (master)    imem_req_*/imem_rsp_* memory channel, id_* decode channel
//   redirect_valid  taken branch/jump, overrides everything this cycle
//   redirect_pc     new fetch target, low two bits ignored
//   q_count         prefetch queue occupancy
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int              XLEN     = CORE_XLEN,
  parameter int              DEPTH    = DEPTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  if_prefetch_unit_if.master   bus,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic [CW-1:0]        q_count
);
  logic [XLEN-1:0]    fetch_pc, expect_pc, redirect_tgt;
  logic [CW-1:0]      outstanding, drop, out_next;
  logic [CW:0]        in_use;
  logic               credit_ok, req_fire, rsp, keep_rsp, pop, q_empty;
  logic [XLEN+31:0]   head;
  logic               unused_pc_lo;

  assign unused_pc_lo = ^redirect_pc[1:0];
  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

  // Every in-flight request owns a queue slot, so a response can always
  // be pushed without backpressuring memory.
  assign in_use    = {1'b0, q_count} + {1'b0, outstanding};
  assign credit_ok = in_use < (CW+1)'(DEPTH);

  assign bus.imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign bus.imem_req_addr  = fetch_pc;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp      = bus.imem_rsp_valid;
  // Responses to pre-redirect requests (drop>0) and any response landing in
  // the redirect cycle itself never enter the queue.
  assign keep_rsp = rsp && !redirect_valid && (drop == '0);
  assign pop      = bus.id_valid && bus.id_ready && !redirect_valid;
  assign out_next = outstanding + CW'(req_fire) - CW'(rsp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      expect_pc   <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        // Whatever is still in flight after this cycle belongs to the old
        // stream; recomputed from live count so stacked redirects stay exact.
        fetch_pc  <= redirect_tgt;
        expect_pc <= redirect_tgt;
        drop      <= out_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp) begin
          if (drop != '0) drop      <= drop - CW'(1);
          else            expect_pc <= expect_pc + XLEN'(4);
        end
      end
    end
  end

  sync_fifo #(.WIDTH(XLEN + 32), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (keep_rsp),
    .push_data ({expect_pc, bus.imem_rsp_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign bus.id_valid = !q_empty;
  assign bus.id_pc    = head[XLEN+31:32];
  assign bus.id_inst  = head[31:0];
endmodule
